// File: rtl/cmd_sequencer_if.sv
// Command channel between cmd_sequencer (master) and RemoteComm (slave):
// one-cycle send strobe plus command word out, sent/response handshake back.
interface cmd_sequencer_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (output snd_cmd, cmd, input cmd_snt, resp_rdy, resp);
  modport slave  (input snd_cmd, cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/cmd_sequencer.sv
// Queues 16-bit Knight commands and plays them through RemoteComm one at a
// time, checking each response byte against a positive acknowledge.
module cmd_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TMO_CLKS = 100_000_000,
  parameter logic [7:0]  POS_ACK  = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [15:0]     wr_cmd,
  output logic            full,
  output logic            empty,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [7:0]      cmds_done,
  cmd_sequencer_if.master rc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = 27;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TMO_CLKS);

  localparam logic [1:0] NO_ERR    = 2'b00;
  localparam logic [1:0] ERR_NACK  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_ERROR
  } state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic          snd_cmd_q;
  logic [15:0]   cmd_q;

  logic          push;
  logic          tmo_hit;
  logic          ack;
  logic          issue;
  logic [1:0]    fail_code;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = wr_en && !full;

  assign tmo_hit = (tmo_cnt == TMO_LIMIT);
  assign ack     = rc.resp_rdy && (rc.resp == POS_ACK);

  assign rc.snd_cmd = snd_cmd_q;
  assign rc.cmd     = cmd_q;

  // NOTE: storage carries no reset; validity is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + PW'(1);
  end

  // Abort outranks every handshake; responses are only looked at in WAIT_RESP.
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    fail_code = NO_ERR;
    issue     = 1'b0;
    unique case (state)
      S_IDLE:      issue = start && !empty;
      S_ISSUE:     if (abort) fail_code = ERR_ABORT;
      S_WAIT_SNT: begin
        if (abort)                        fail_code = ERR_ABORT;
        else if (!rc.cmd_snt && tmo_hit)  fail_code = ERR_TMO;
      end
      S_WAIT_RESP: begin
        if (abort)                        fail_code = ERR_ABORT;
        else if (rc.resp_rdy && !ack)     fail_code = ERR_NACK;
        else if (!rc.resp_rdy && tmo_hit) fail_code = ERR_TMO;
        else                              issue = ack && !empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      tmo_cnt   <= '0;
      snd_cmd_q <= 1'b0;
      cmd_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= NO_ERR;
      cmds_done <= '0;
    end else begin
      snd_cmd_q <= 1'b0;
      done      <= 1'b0;
      tmo_cnt   <= '0;
      if (fail_code != NO_ERR) begin
        state    <= S_ERROR;
        err      <= 1'b1;
        err_code <= fail_code;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && empty) done <= 1'b1;
            if (issue) begin
              err       <= 1'b0;
              err_code  <= NO_ERR;
              cmds_done <= '0;
            end
          end
          S_ISSUE: state <= S_WAIT_SNT;
          S_WAIT_SNT: begin
            if (rc.cmd_snt) state <= S_WAIT_RESP;
            else            tmo_cnt <= tmo_cnt + TW'(1);
          end
          S_WAIT_RESP: begin
            if (ack) begin
              if (cmds_done != 8'hFF) cmds_done <= cmds_done + 8'd1;
              if (empty) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_ERROR: begin
            rd_ptr <= wr_ptr;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
        // Loading the head into the cmd register is the pop.
        if (issue) begin
          cmd_q     <= mem[rd_ptr[AW-1:0]];
          rd_ptr    <= rd_ptr + PW'(1);
          snd_cmd_q <= 1'b1;
          busy      <= 1'b1;
          state     <= S_ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: random RemoteComm responder, list-based model of
// what should be sent and acknowledged, directed corner-case steps.
module tb_cmd_sequencer;

  localparam int         DEPTH = 8;
  localparam int         TMO   = 1000;
  localparam logic [7:0] ACK   = 8'hA5;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        wr_en  = 1'b0;
  logic [15:0] wr_cmd = '0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic        full, empty, busy, done, err;
  logic [1:0]  err_code;
  logic [7:0]  cmds_done;

  cmd_sequencer_if rc();

  // Responder-side and manual-side drivers are merged onto the channel.
  logic       r_snt = 1'b0, r_rdy = 1'b0, m_snt = 1'b0, m_rdy = 1'b0;
  logic [7:0] r_resp = '0, m_resp = '0;
  assign rc.cmd_snt  = r_snt | m_snt;
  assign rc.resp_rdy = r_rdy | m_rdy;
  assign rc.resp     = m_rdy ? m_resp : r_resp;

  cmd_sequencer #(.DEPTH(DEPTH), .TMO_CLKS(TMO), .POS_ACK(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd),
    .full(full), .empty(empty), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cmds_done(cmds_done), .rc(rc)
  );

  always #5 clk = ~clk;

  logic [15:0] sent_q[$];
  int          done_cnt  = 0;
  bit          auto_resp = 1'b0;
  int          nack_abs  = -1;
  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [15:0] fixed_cmds [3] = '{16'h2000, 16'h47F3, 16'h4BF1};

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // RemoteComm + KnightsTour stand-in: logs every frame, and in auto mode
  // reports it sent and answers (NACK on the chosen absolute command index).
  initial begin : responder
    int k;
    forever begin
      @(negedge clk);
      if (rst_n && rc.snd_cmd === 1'b1) begin
        sent_q.push_back(rc.cmd);
        k = sent_q.size();
        if (auto_resp) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          r_snt = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            r_rdy  = 1'b1;
            r_resp = 8'h00;
          end
          @(posedge clk); #1;
          r_snt = 1'b0;
          r_rdy = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          r_resp = (k == nack_abs) ? 8'h5A : ACK;
          r_rdy  = 1'b1;
          @(posedge clk); #1;
          r_rdy  = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c);
    wr_en  = 1'b1;
    wr_cmd = c;
    @(posedge clk); #1;
    wr_en  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cyc = 0;
    while (busy !== 1'b0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/bounded"}, 32'(cyc < budget), 1);
  endtask

  // Manual handshake from the ISSUE cycle up to the first WAIT_RESP cycle.
  task automatic manual_snt();
    @(posedge clk); #1;
    m_snt = 1'b1;
    @(posedge clk); #1;
    m_snt = 1'b0;
  endtask

  // Queue n commands, run them with the auto responder and compare the
  // observed traffic against the list: nack_at (1-based) or 0 for none.
  task automatic run_seq(input string tag, input int n, input int nack_at, input bit fixed);
    int          base, dbase, sent_n, acked;
    logic [15:0] c;
    logic [15:0] exp_l[$];
    base  = sent_q.size();
    dbase = done_cnt;
    for (int i = 0; i < n; i++) begin
      c = (fixed && i < 3) ? fixed_cmds[i] : 16'($urandom);
      push(c);
      exp_l.push_back(c);
    end
    nack_abs  = (nack_at == 0) ? -1 : base + nack_at;
    auto_resp = 1'b1;
    pulse_start();
    wait_idle(tag, 2000);
    repeat (20) @(posedge clk);
    #1;
    sent_n = (nack_at == 0) ? n : nack_at;
    acked  = (nack_at == 0) ? n : nack_at - 1;
    check({tag, "/sent"}, 32'(sent_q.size() - base), 32'(sent_n));
    for (int i = 0; i < sent_n && base + i < sent_q.size(); i++)
      check($sformatf("%s/cmd%0d", tag, i), 32'(sent_q[base + i]), 32'(exp_l[i]));
    check({tag, "/cmds_done"}, 32'(cmds_done), 32'(acked));
    check({tag, "/err"}, 32'(err), (nack_at == 0) ? 0 : 1);
    check({tag, "/err_code"}, 32'(err_code), (nack_at == 0) ? 0 : 1);
    check({tag, "/done"}, 32'(done_cnt - dbase), (nack_at == 0) ? 1 : 0);
    check({tag, "/empty"}, 32'(empty), 1);
  endtask

  initial begin : main
    int          base, dbase, cyc;
    logic [15:0] c;
    logic [15:0] exp_l[$];

    // Reset values
    #12;
    check("rst/empty", 32'(empty), 1);
    check("rst/full", 32'(full), 0);
    check("rst/busy", 32'(busy), 0);
    check("rst/done", 32'(done), 0);
    check("rst/err", 32'(err), 0);
    check("rst/err_code", 32'(err_code), 0);
    check("rst/cmds_done", 32'(cmds_done), 0);
    check("rst/snd_cmd", 32'(rc.snd_cmd), 0);
    check("rst/cmd", 32'(rc.cmd), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal run with the fixed Knight commands
    run_seq("normal", 3, 0, 1'b1);

    // Negative acknowledge on the second of three
    run_seq("nack", 3, 2, 1'b0);

    // Randomized runs against the list model
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      run_seq($sformatf("rand%0d", r), n, $urandom_range(0, n), 1'b0);
    end

    // Timeout: cmd_snt never arrives
    auto_resp = 1'b0;
    push(16'h1234);
    pulse_start();
    check("tmo/snd_cmd", 32'(rc.snd_cmd), 1);
    check("tmo/err_clr", 32'(err), 0);
    cyc = 0;
    while (err_code !== 2'b10 && cyc < TMO + 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("tmo/latency", 32'(cyc - 1), 32'(TMO + 1));
    check("tmo/err", 32'(err), 1);
    check("tmo/busy_err_cycle", 32'(busy), 1);
    @(posedge clk); #1;
    check("tmo/busy_drop", 32'(busy), 0);
    check("tmo/empty", 32'(empty), 1);

    // Abort in the same WAIT_RESP cycle as an accepted ACK
    base = sent_q.size();
    push(16'h0AAA);
    push(16'h0BBB);
    pulse_start();
    manual_snt();
    abort  = 1'b1;
    m_resp = ACK;
    m_rdy  = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    m_rdy = 1'b0;
    check("abort/err_code", 32'(err_code), 3);
    check("abort/err", 32'(err), 1);
    check("abort/cmds_done", 32'(cmds_done), 0);
    @(posedge clk); #1;
    check("abort/busy", 32'(busy), 0);
    check("abort/empty", 32'(empty), 1);
    repeat (5) @(posedge clk);
    #1;
    check("abort/sent", 32'(sent_q.size() - base), 1);

    // Queue boundaries: fill, overfill, run, append mid-run
    exp_l.delete();
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fill/full%0d", i), 32'(full), 0);
      c = 16'($urandom);
      push(c);
      exp_l.push_back(c);
    end
    check("fill/full", 32'(full), 1);
    push(16'hDEAD);
    check("fill/full_after_drop", 32'(full), 1);
    base  = sent_q.size();
    dbase = done_cnt;
    nack_abs  = -1;
    auto_resp = 1'b1;
    pulse_start();
    cyc = 0;
    while (sent_q.size() < base + 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("fill/progress", 32'(cyc < 200), 1);
    c = 16'hC0DE;
    push(c);
    exp_l.push_back(c);
    wait_idle("fill", 2000);
    repeat (20) @(posedge clk);
    #1;
    check("fill/sent", 32'(sent_q.size() - base), 32'(DEPTH + 1));
    for (int i = 0; i < DEPTH + 1 && base + i < sent_q.size(); i++)
      check($sformatf("fill/cmd%0d", i), 32'(sent_q[base + i]), 32'(exp_l[i]));
    check("fill/cmds_done", 32'(cmds_done), 32'(DEPTH + 1));
    check("fill/done", 32'(done_cnt - dbase), 1);

    // Start on an empty queue
    base = sent_q.size();
    pulse_start();
    check("estart/done", 32'(done), 1);
    check("estart/busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("estart/done_pulse", 32'(done), 0);
    repeat (5) @(posedge clk);
    #1;
    check("estart/no_snd", 32'(sent_q.size() - base), 0);

    // Reset in WAIT_RESP after one acknowledged command
    auto_resp = 1'b0;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    pulse_start();
    manual_snt();
    m_resp = ACK;
    m_rdy  = 1'b1;
    @(posedge clk); #1;
    m_rdy = 1'b0;
    manual_snt();
    check("mrst/pre_cmds_done", 32'(cmds_done), 1);
    check("mrst/pre_cmd", 32'(rc.cmd), 32'h2222);
    rst_n = 1'b0;
    #1;
    check("mrst/cmd", 32'(rc.cmd), 0);
    check("mrst/snd_cmd", 32'(rc.snd_cmd), 0);
    check("mrst/busy", 32'(busy), 0);
    check("mrst/done", 32'(done), 0);
    check("mrst/err", 32'(err), 0);
    check("mrst/err_code", 32'(err_code), 0);
    check("mrst/cmds_done", 32'(cmds_done), 0);
    check("mrst/empty", 32'(empty), 1);
    check("mrst/full", 32'(full), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq("post_rst", 3, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
